mult_div_sequencer: RTL and testbench

//   Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO; owns the architectural HI/LO registers.

---
 rtl/mips_multdiv_pkg.sv | 26 ++
 rtl/multdiv_iter_step.sv | 39 +++
 rtl/mult_div_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_multdiv_pkg.sv
// Shared types for the MIPS multiply/divide sequencer: opcodes, FSM states, counter sizing.
package mips_multdiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  // Counter must be able to hold the full iteration count, not just WIDTH-1.
  function automatic int iter_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int ITER_CNT_W = iter_cnt_w(32);

endpackage

// File: rtl/multdiv_iter_step.sv
// One radix-2 iteration: LSB-first shift-add multiply or restoring-subtract divide.
module multdiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             is_div_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shreg_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i} + {1'b0, opnd_i};
    shifted = {acc_i, shreg_i[WIDTH-1]};
    // The partial remainder after a successful subtract is below the divisor, so it fits WIDTH bits.
    diff    = shifted[WIDTH-1:0] - opnd_i;
    if (is_div_i) begin
      if (shifted >= {1'b0, opnd_i}) begin
        acc_o   = diff;
        shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o   = shifted[WIDTH-1:0];
        shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
      end
    end else if (shreg_i[0]) begin
      acc_o   = sum[WIDTH:1];
      shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
    end else begin
      acc_o   = {1'b0, acc_i[WIDTH-1:1]};
      shreg_o = {acc_i[0], shreg_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// MIPS HI/LO owner: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Define MULTDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module mult_div_sequencer
  import mips_multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = iter_cnt_w(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, shreg_q, shreg_d, opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  op_t                op_in;
  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs, step_acc, step_shreg, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod_fix;

  multdiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .shreg_i  (shreg_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc),
    .shreg_o  (step_shreg)
  );

  assign op_in     = op_t'(op);
  assign is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign a_neg     = is_signed && a[WIDTH-1];
  assign b_neg     = is_signed && b[WIDTH-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;
  assign prod_fix  = neg_res_q ? -{acc_q, shreg_q} : {acc_q, shreg_q};
  assign q_fix     = neg_res_q ? -shreg_q : shreg_q;
  assign r_fix     = neg_rem_q ? -acc_q : acc_q;

`ifdef MULTDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] sprod, uprod;
  assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  always_comb begin
    // NOTE: every _d starts from its _q (done from 0) so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        case (op_in)
          OP_MULT, OP_MULTU: begin
            dz_d = 1'b0;
`ifdef MULTDIV_FAST_MUL_EN
            {hi_d, lo_d} = is_signed ? sprod : uprod;
            done_d       = 1'b1;
`else
            state_d   = RUN;
            busy_d    = 1'b1;
            cnt_d     = '0;
            is_div_d  = 1'b0;
            acc_d     = '0;
            shreg_d   = b_abs;
            opnd_d    = a_abs;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = 1'b0;
`endif
          end
          OP_DIV, OP_DIVU: begin
            state_d  = RUN;
            busy_d   = 1'b1;
            cnt_d    = '0;
            is_div_d = 1'b1;
            acc_d    = '0;
            dz_d     = (b == '0);
            // Restoring divide by zero naturally yields remainder=dividend, quotient=all-ones.
            if (b == '0) begin
              shreg_d   = a;
              opnd_d    = '0;
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
            end else begin
              shreg_d   = a_abs;
              opnd_d    = b_abs;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
            end
          end
          OP_MTHI: begin
            hi_d   = a;
            done_d = 1'b1;
          end
          OP_MTLO: begin
            lo_d   = a;
            done_d = 1'b1;
          end
          default: ;
        endcase
      end
      RUN: begin
        acc_d   = step_acc;
        shreg_d = step_shreg;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = q_fix;
          hi_d = r_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments only, so every flop sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      shreg_q   <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      shreg_q   <= shreg_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q && !reset;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer; latency expectations follow MULTDIV_FAST_MUL_EN.
module tb_mult_div_sequencer;
  import mips_multdiv_pkg::*;

  localparam int W        = 32;
  localparam int DIV_BUSY = W + 1;
`ifdef MULTDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = W + 1;
`endif

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd7;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mult_div_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_hi", hi, e.hi);
          check("sb_lo", lo, e.lo);
          check("sb_div_zero", div_zero, e.dz);
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                        input int exp_busy, input int inject_at);
    exp_t e;
    int   busy_n = 0;
    bit   seen = 0;
    e.hi = eh;
    e.lo = el;
    e.dz = edz;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_n++;
      if (i == inject_at) begin
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'h0000_1234;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("busy_cycles", busy_n, exp_busy);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dz", div_zero, 0);
    reset = 1'b0;

    run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_BUSY, -1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_BUSY, -1);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, DIV_BUSY, -1);
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, MUL_BUSY, -1);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_BUSY, -1);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'd0, 32'd12, 1'b0, MUL_BUSY, -1);
    run_op(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, DIV_BUSY, -1);
    run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, MUL_BUSY, -1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, DIV_BUSY, -1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, DIV_BUSY, -1);
    run_op(OP_MTHI, 32'h0000_ABCD, 32'd0, 32'h0000_ABCD, 32'hFFFF_FFFF, 1'b1, 0, -1);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_BUSY, 5);
    run_op(OP_MTLO, 32'h0000_1234, 32'd0, 32'd2, 32'h0000_1234, 1'b0, 0, -1);

    // Reserved opcode: no done, no state change.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd7;
    a     = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) seen = 1;
      @(negedge clk);
    end
    check("noop_activity", seen, 0);
    check("noop_hi", hi, 32'd2);
    check("noop_lo", lo, 32'h0000_1234);

    // Reset during a divide aborts it with no done pulse.
    start = 1'b1;
    op    = OP_DIV;
    a     = 32'd1000;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle_busy", busy, 0);

    run_op(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, DIV_BUSY, -1);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
